// File: rtl/net_cmd_dispatch_if.sv
// net_cmd_dispatch_if: network-side command handshake (valid/ready plus
// the packet fields) between the on-chip network and net_cmd_dispatch.
interface net_cmd_dispatch_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              net_valid_i;
    logic [2:0]        net_op_i;
    logic [ADDR_W-1:0] net_addr_i;
    logic [DATA_W-1:0] net_data_i;
    logic              net_ready_o;

    // network side: presents packets, observes ready
    modport master (
        output net_valid_i,
        output net_op_i,
        output net_addr_i,
        output net_data_i,
        input  net_ready_o
    );

    // dispatcher side: consumes packets, drives ready
    modport slave (
        input  net_valid_i,
        input  net_op_i,
        input  net_addr_i,
        input  net_data_i,
        output net_ready_o
    );
endinterface

// File: rtl/net_cmd_dispatch.sv
// net_cmd_dispatch: buffers network command packets in a small FIFO and
// dispatches the head as a one-cycle write strobe (imem/dmem/reg) or a PC
// write that kicks the core from IDLE to RUN. Writes only land while the
// core is IDLE; in RUN the head is held, in ERR it is dropped.
// Optional macro NET_CMD_STATS_EN adds saturating dispatch/drop counters.
module net_cmd_dispatch #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              n_reset,
    net_cmd_dispatch_if.slave net,
    input  logic [1:0]        state_i,
    input  logic              stall_i,
    output logic              imem_we_o,
    output logic              dmem_we_o,
    output logic              reg_we_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              net_PC_write_cmd_IDLE_o,
    output logic              illegal_op_o
`ifdef NET_CMD_STATS_EN
    ,
    output logic [15:0]       dispatch_count_o,
    output logic [15:0]       drop_count_o
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] OP_IMEM = 3'd1;
    localparam logic [2:0] OP_DMEM = 3'd2;
    localparam logic [2:0] OP_REG  = 3'd3;
    localparam logic [2:0] OP_PC   = 3'd4;

    typedef struct packed {
        logic [2:0]        op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    cmd_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    cmd_t head;
    logic empty;
    logic full;
    logic enq;
    logic deq;
    logic st_idle;
    logic st_run;
    logic st_err;
    logic is_wr;
    logic is_pc;
    logic is_ill;
    logic hold;
    logic fire_imem;
    logic fire_dmem;
    logic fire_reg;
    logic fire_pc;
    logic fire_ill;
    logic fire_drop;

    // Ready is forced low while reset is asserted so nothing is offered
    // to a FIFO that is being flushed.
    assign full            = (count == CNT_W'(FIFO_DEPTH));
    assign empty           = (count == '0);
    assign net.net_ready_o = n_reset & ~full;
    assign enq             = net.net_valid_i & net.net_ready_o;

    // FIFO storage: data is not reset, only the pointers are flushed
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= '{op: net.net_op_i, addr: net.net_addr_i, data: net.net_data_i};
        end
    end

    // FIFO pointers and occupancy; simultaneous enq/deq leaves count unchanged
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Dispatch decision on the FIFO head. State 3 folds into ERR, so any
    // state with bit 1 set drops writes. Illegal ops drain in every state
    // so a bad packet can never wedge the queue behind a RUN core.
    always_comb begin
        head      = mem[rd_ptr];
        st_idle   = (state_i == 2'd0);
        st_run    = (state_i == 2'd1);
        st_err    = state_i[1];
        is_wr     = (head.op == OP_IMEM) || (head.op == OP_DMEM) || (head.op == OP_REG);
        is_pc     = (head.op == OP_PC);
        is_ill    = head.op[2] & (head.op[1] | head.op[0]);
        hold      = st_run & (is_wr | is_pc);
        deq       = ~empty & ~stall_i & ~hold;
        fire_imem = deq & st_idle & (head.op == OP_IMEM);
        fire_dmem = deq & st_idle & (head.op == OP_DMEM);
        fire_reg  = deq & st_idle & (head.op == OP_REG);
        fire_pc   = deq & st_idle & is_pc;
        fire_ill  = deq & is_ill;
        fire_drop = deq & st_err & (is_wr | is_pc);
    end

    // Registered strobes; address/data only move on an actual write so the
    // shared bus holds the last written values between strobes.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            imem_we_o               <= 1'b0;
            dmem_we_o               <= 1'b0;
            reg_we_o                <= 1'b0;
            net_PC_write_cmd_IDLE_o <= 1'b0;
            illegal_op_o            <= 1'b0;
            wr_addr_o               <= '0;
            wr_data_o               <= '0;
            pc_o                    <= '0;
        end else begin
            imem_we_o               <= fire_imem;
            dmem_we_o               <= fire_dmem;
            reg_we_o                <= fire_reg;
            net_PC_write_cmd_IDLE_o <= fire_pc;
            illegal_op_o            <= fire_ill;
            if (fire_imem | fire_dmem | fire_reg) begin
                wr_addr_o <= head.addr;
                wr_data_o <= head.data;
            end
            if (fire_pc) begin
                pc_o <= head.addr;
            end
        end
    end

`ifdef NET_CMD_STATS_EN
    // Saturating counters of accepted dispatches and discarded packets
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            dispatch_count_o <= '0;
            drop_count_o     <= '0;
        end else begin
            if ((fire_imem | fire_dmem | fire_reg | fire_pc) && (dispatch_count_o != 16'hFFFF)) begin
                dispatch_count_o <= dispatch_count_o + 16'd1;
            end
            if ((fire_drop | fire_ill) && (drop_count_o != 16'hFFFF)) begin
                drop_count_o <= drop_count_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/net_cmd_dispatch.md
Name: net_cmd_dispatch

Overview:
- Upstream of the core's next-state logic.
- Accepts command packets from the on-chip network through a valid/ready handshake and buffers them in a small FIFO.
- Dispatches each packet as a one-cycle write strobe to instruction memory, data memory, register file or PC.
- Produces net_PC_write_cmd_IDLE_o, the pulse that moves the core from IDLE to RUN. Memory and register writes are gated so they only land while the core is IDLE.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of two, at least 2.
- ADDR_W, 10, address width for imem/dmem/reg/PC writes.
- DATA_W, 32, payload width.

Ports:
- clk  in  1  clock.
- n_reset  in  1  synchronous reset, active-low.
- net_valid_i  in  1  packet valid.
- net_op_i  in  3  op code: 0 NOP, 1 IMEM_WR, 2 DMEM_WR, 3 REG_WR, 4 PC_WR; 5-7 illegal.
- net_addr_i  in  ADDR_W  target address, or PC value for PC_WR.
- net_data_i  in  DATA_W  payload.
- net_ready_o  out  1  FIFO can accept a packet.
- state_i  in  2  core state, registered: 0 IDLE, 1 RUN, 2 ERR.
- stall_i  in  1  core stall; suppresses dispatch.
- imem_we_o, dmem_we_o, reg_we_o  out  1 each  write strobes.
- wr_addr_o  out  ADDR_W  address shared by all write strobes.
- wr_data_o  out  DATA_W  data shared by all write strobes.
- pc_o  out  ADDR_W  new PC, valid while net_PC_write_cmd_IDLE_o is high.
- net_PC_write_cmd_IDLE_o  out  1  PC write accepted while IDLE.
- illegal_op_o  out  1  one-cycle pulse when an illegal op is dropped.

Behaviour:
- Reset (n_reset low at a clk edge):
  - FIFO is flushed: count 0, pointers 0.
  - All strobes, illegal_op_o, wr_addr_o, wr_data_o and pc_o go to 0.
  - net_ready_o reads 0 during reset and 1 on the first cycle after reset.
  - Reset mid-stream discards all queued packets. No partial dispatch occurs.
- Enqueue:
  - net_ready_o = ~full.
  - A packet enqueues at the edge where net_valid_i & net_ready_o.
  - Enqueue and dequeue in the same cycle are both allowed, and count is unchanged.
  - When full, no enqueue happens, even if a dequeue occurs in the same cycle; there is no bypass.
- Dispatch decision (combinational on the FIFO head; only taken when not empty and stall_i = 0):
  - NOP: dequeue, no strobe.
  - IMEM_WR, DMEM_WR, REG_WR:
    - state IDLE: dequeue and assert the matching strobe.
    - state RUN: hold the head; nothing dequeues until state_i returns to IDLE.
    - state ERR: dequeue and drop silently.
  - PC_WR:
    - state IDLE: dequeue; net_PC_write_cmd_IDLE_o = 1, pc_o = head addr.
    - state RUN: hold the head.
    - state ERR: dequeue and drop.
  - Illegal op (5-7): dequeue in any state; pulse illegal_op_o.
- Outputs and latency:
  - All outputs except net_ready_o are registered.
  - Strobes are high for exactly one cycle.
  - Latency: a packet accepted at edge N is dispatched at edge N+1, so its strobe is high during the cycle after edge N+1, provided the head is unblocked.
  - At most one dispatch per cycle, in FIFO order.
  - A held head blocks all packets behind it; there is no reordering.
- state_i = 3 (invalid) is treated as ERR.

Optional Feature:
- Macro NET_CMD_STATS_EN.
- When defined, adds two outputs:
  - dispatch_count_o (16 bits): increments on every strobe or net_PC_write_cmd_IDLE_o.
  - drop_count_o (16 bits): increments on every ERR-state drop or illegal op.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined, these ports and counters do not exist and the rest of the behaviour is identical.

Test Plan:
- state IDLE; send IMEM_WR addr 0x010 data 0xDEADBEEF -> imem_we_o high for exactly one cycle, two cycles after acceptance, with wr_addr_o 0x010 and wr_data_o 0xDEADBEEF; other strobes 0.
- state RUN; send DMEM_WR then PC_WR 0x020; switch state to IDLE 10 cycles later -> nothing dispatched while RUN; after the switch, dmem_we_o pulses, then the next cycle net_PC_write_cmd_IDLE_o pulses with pc_o 0x020.
- Hold stall_i high while sending 6 packets -> net_ready_o drops after 4 accepted and no dispatch occurs; release stall_i -> 4 strobes on consecutive cycles, in order.
- state ERR; send REG_WR and op 6 -> no reg_we_o; one illegal_op_o pulse; FIFO empties.
- FIFO with 3 entries; assert n_reset for one cycle -> outputs 0, net_ready_o high next cycle, no queued packet ever dispatched.
- With NET_CMD_STATS_EN defined, run the three previous scenarios -> counters match the dispatch and drop totals.
